inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Produces the instruction stream that feeds the opcode decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents each fetched instruction to the decode stage with a valid/ready handshake.
- Consumes the decoder's branch strobe together with the ALU zero flag to redirect the PC.

Parameters:
- XLEN, 32, width of PC, addresses and instruction word.
- RESET_PC, 0, PC value loaded on reset (bits [1:0] forced to 0).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; addr must be stable while req=1 and ack=0.
- imem_addr  output  XLEN  word-aligned fetch address.
- imem_ack  input  1  one-cycle strobe; imem_rdata valid this cycle; ends one transaction.
- imem_rdata  input  XLEN  returned instruction word.
- inst_out  output  XLEN  instruction to decode; bits [6:0] are the opcode.
- pc_out  output  XLEN  address of inst_out.
- inst_valid  output  1  inst_out/pc_out valid.
- inst_ready  input  1  decode accepts the instruction when inst_valid & inst_ready.
- branch  input  1  branch strobe from the decoder, for the resolving instruction.
- zero  input  1  ALU zero flag for the same instruction.
- branch_pc  input  XLEN  PC of the resolving branch.
- br_offset  input  XLEN  signed byte offset (two's complement).

Behaviour:
- States: FETCH (request outstanding) and HOLD (instruction presented). Internal squash flag.
- Redirect condition: redirect = branch & zero, sampled every cycle.
- Redirect target: (branch_pc + br_offset) mod 2^XLEN, bits [1:0] forced to 0.
- Reset (rst=1 at an edge):
  - state=FETCH, pc=RESET_PC, squash=0.
  - inst_valid=0, inst_out=0, pc_out=0.
  - imem_req=0 while rst is high; imem_req=1 with imem_addr=RESET_PC in the first cycle after rst drops.
  - Reset mid-transaction: a later ack belonging to the aborted request arrives while the new request is outstanding and is accepted as its response. The memory is required to drop requests on rst.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - ack & !squash & !redirect: inst_out<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4 (wraps to 0 past 2^XLEN-4), go to HOLD. imem_req=0 next cycle.
  - ack & (squash | redirect): data discarded, squash<=0, pc<=target (latest redirect wins; the squash-only case keeps the already-loaded target), stay FETCH. Next cycle starts a new transaction at the new address.
  - redirect & !ack: pc<=target, squash<=1. imem_addr keeps the old value until ack (address stability rule). The new address is issued after that ack.
- HOLD:
  - imem_req=0; inst_out and pc_out held stable.
  - inst_ready & !redirect: inst_valid<=0, go to FETCH (request at pc next cycle).
  - redirect (any inst_ready): the held instruction is wrong-path and is dropped. inst_valid<=0, pc<=target, go to FETCH. The handshake in that cycle does not count as a transfer; decode must ignore it.
- Throughput: with single-cycle-ack memory, one instruction every 3 cycles (FETCH, HOLD, FETCH). No prefetch buffer.
- branch=1 with zero=0, or zero=1 with branch=0: no effect.

Test Plan:
- Reset, then ack 1 cycle after req with rdata=0x00000033 → inst_valid=1, inst_out=0x00000033, pc_out=0x0. Next req addr=0x4.
- inst_valid=1 with inst_ready=0 for 3 cycles → inst_out/pc_out stable, imem_req=0. Then ready=1 → req addr=0x8 the next cycle.
- In HOLD (pc_out=0x10): branch=1, zero=1, branch_pc=0x10, br_offset=0xFFFFFFF8 → inst_valid=0 next cycle, then req addr=0x8, next delivered pc_out=0x8.
- Redirect to 0x40 while FETCH at 0x20 waits (ack 2 cycles later, rdata=0xDEADBEEF) → 0xDEADBEEF never presented, imem_addr stays 0x20 until ack, next req addr=0x40.
- branch=1/zero=0 and branch=0/zero=1 during HOLD → no redirect, sequential PCs continue.
- RESET_PC=0xFFFFFFFC → first pc_out=0xFFFFFFFC, next req addr=0x0.
- rst asserted during FETCH → imem_req=0 during reset, first post-reset req addr=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word at a time from
// instruction memory over a req/ack handshake, and presents each word to
// decode over a valid/ready handshake. A taken branch (branch & zero)
// redirects the PC. Wrong-path data is squashed, whether it is still in
// flight or already being presented.
//
// Handshakes:
//   imem: imem_req stays high with imem_addr stable until a one-cycle
//         imem_ack. The ack carries imem_rdata and ends the transaction.
//   decode: a transfer happens on a cycle with inst_valid & inst_ready and
//         no redirect. inst_out/pc_out stay stable while inst_valid=1 and
//         the instruction is not accepted.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] pc_out,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] br_offset,
  output logic            dbg_state_o
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] PC_RST = {RESET_PC[XLEN-1:2], 2'b00};

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic            squash_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_out_q;
  logic            valid_q;

  logic            redirect_d;
  logic [XLEN-1:0] target_sum_d;
  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] pc_seq_d;

  // Branch resolution and sequential PC. Both additions wrap modulo 2^XLEN.
  always_comb begin
    redirect_d   = branch & zero;
    target_sum_d = branch_pc + br_offset;
    target_d     = {target_sum_d[XLEN-1:2], 2'b00};
    pc_seq_d     = pc_q + XLEN'(4);
  end

  // FETCH/HOLD state machine with PC, squash flag and the decode outputs.
  // addr_q is the address of the current request. It is frozen while a
  // request waits for its ack, so a redirect in that window only updates
  // pc_q and sets squash_q. The new address goes out after the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= PC_RST;
      addr_q   <= PC_RST;
      squash_q <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            if (!squash_q && !redirect_d) begin
              inst_q   <= imem_rdata;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_seq_d;
              addr_q   <= pc_seq_d;
              state_q  <= HOLD;
            end else begin
              // Wrong-path response. The latest redirect wins. Otherwise pc_q
              // already holds the target from the earlier redirect.
              squash_q <= 1'b0;
              if (redirect_d) begin
                pc_q   <= target_d;
                addr_q <= target_d;
              end else begin
                addr_q <= pc_q;
              end
            end
          end else if (redirect_d) begin
            pc_q     <= target_d;
            squash_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_d) begin
            // Held instruction is wrong-path. Drop it regardless of ready.
            valid_q <= 1'b0;
            pc_q    <= target_d;
            addr_q  <= target_d;
            state_q <= FETCH;
          end else if (inst_ready) begin
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Request is gated by rst so it is low for the whole reset period.
  always_comb begin
    imem_req    = (state_q == FETCH) && !rst;
    imem_addr   = addr_q;
    inst_out    = inst_q;
    pc_out      = pc_out_q;
    inst_valid  = valid_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit. The main instance uses RESET_PC=0. A
// second instance uses RESET_PC=0xFFFFFFFC to cover PC wrap-around.
module tb_inst_fetch_unit;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [XLEN-1:0] imem_rdata = '0;
  logic [XLEN-1:0] inst_out;
  logic [XLEN-1:0] pc_out;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic            branch = 1'b0;
  logic            zero = 1'b0;
  logic [XLEN-1:0] branch_pc = '0;
  logic [XLEN-1:0] br_offset = '0;
  logic            dbg_state;

  logic            rst2 = 1'b1;
  logic            imem_req2;
  logic [XLEN-1:0] imem_addr2;
  logic            imem_ack2 = 1'b0;
  logic [XLEN-1:0] imem_rdata2 = '0;
  logic [XLEN-1:0] inst_out2;
  logic [XLEN-1:0] pc_out2;
  logic            inst_valid2;
  logic            inst_ready2 = 1'b0;
  logic            dbg_state2;

  inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .branch(branch), .zero(zero),
    .branch_pc(branch_pc), .br_offset(br_offset),
    .dbg_state_o(dbg_state)
  );

  inst_fetch_unit #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .inst_out(inst_out2), .pc_out(pc_out2),
    .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .branch(1'b0), .zero(1'b0),
    .branch_pc(32'h0), .br_offset(32'h0),
    .dbg_state_o(dbg_state2)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: {pc, inst} pushed when an accepted ack is driven, popped
  // when the DUT begins presenting a new instruction.
  logic [63:0] exp_q[$];
  logic        seen_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 1'b0;
    end else begin
      if (inst_valid && !seen_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: got pc %h inst %h, none expected", pc_out, inst_out);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("sb_pc_out", pc_out, e[63:32]);
          chk("sb_inst_out", inst_out, e[31:0]);
        end
      end
      seen_valid = inst_valid;
    end
  end

  // ---------------- driver tasks ----------------
  logic [31:0] last_pc = '0;
  logic [31:0] last_inst = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 4) | 32'h33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    #1;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input int lat,
                          input logic [31:0] rdata);
    wait_req();
    chk("req_addr", imem_addr, exp_addr);
    chk("valid_low_in_fetch", {31'b0, inst_valid}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("addr_stable", imem_addr, exp_addr);
      chk("req_held", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    exp_q.push_back({exp_addr, rdata});
    last_pc   = exp_addr;
    last_inst = rdata;
    step();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic do_hold(input int n_wait, input logic br, input logic zr);
    for (int i = 0; i < n_wait; i++) begin
      inst_ready = 1'b0;
      branch     = br;
      zero       = zr;
      branch_pc  = $urandom;
      br_offset  = $urandom;
      #1;
      chk("hold_req_low", {31'b0, imem_req}, 32'd0);
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst_stable", inst_out, last_inst);
      chk("hold_pc_stable", pc_out, last_pc);
      step();
    end
    branch     = 1'b0;
    zero       = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("accept_valid", {31'b0, inst_valid}, 32'd1);
    step();
    inst_ready = 1'b0;
  endtask

  task automatic hold_redirect(input logic [31:0] bpc, input logic [31:0] off,
                               input logic [31:0] exp_target);
    inst_ready = 1'($urandom_range(0, 1));
    branch     = 1'b1;
    zero       = 1'b1;
    branch_pc  = bpc;
    br_offset  = off;
    #1;
    chk("redir_hold_valid_before", {31'b0, inst_valid}, 32'd1);
    step();
    branch     = 1'b0;
    zero       = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("redir_hold_valid_dropped", {31'b0, inst_valid}, 32'd0);
    chk("redir_hold_req", {31'b0, imem_req}, 32'd1);
    chk("redir_hold_addr", imem_addr, exp_target);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          lat;
    int          hold;
    logic        br;
    logic        zr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{lat: 1, hold: 0, br: 1'b0, zr: 1'b0, exp_addr: 32'h0};
    vecs[1] = '{lat: 0, hold: 3, br: 1'b0, zr: 1'b0, exp_addr: 32'h4};
    vecs[2] = '{lat: 0, hold: 2, br: 1'b1, zr: 1'b0, exp_addr: 32'h8};
    vecs[3] = '{lat: 2, hold: 2, br: 1'b0, zr: 1'b1, exp_addr: 32'hC};

    // Reset.
    repeat (3) step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_out", inst_out, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'b0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Sequential fetches with stalls and non-redirecting branch/zero.
    for (int i = 0; i < 4; i++) begin
      do_fetch(vecs[i].exp_addr, vecs[i].lat, mem_word(vecs[i].exp_addr));
      do_hold(vecs[i].hold, vecs[i].br, vecs[i].zr);
    end

    // Redirect in HOLD: 0x10 + (-8) = 0x8.
    do_fetch(32'h10, 0, mem_word(32'h10));
    hold_redirect(32'h10, 32'hFFFF_FFF8, 32'h8);
    do_fetch(32'h8, 1, mem_word(32'h8));
    // Redirect in HOLD with unaligned sum: 0x8 + 0x1B = 0x23 -> 0x20.
    hold_redirect(32'h8, 32'h1B, 32'h20);

    // Redirect while FETCH at 0x20 waits. The late ack is squashed.
    wait_req();
    chk("sq_addr0", imem_addr, 32'h20);
    branch = 1'b1; zero = 1'b1; branch_pc = 32'h30; br_offset = 32'h10;
    step();
    branch = 1'b0; zero = 1'b0;
    #1;
    chk("sq_addr1", imem_addr, 32'h20);
    chk("sq_req1", {31'b0, imem_req}, 32'd1);
    step();
    chk("sq_addr2", imem_addr, 32'h20);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    #1;
    chk("sq_valid", {31'b0, inst_valid}, 32'd0);
    chk("sq_new_addr", imem_addr, 32'h40);
    do_fetch(32'h40, 0, mem_word(32'h40));
    do_hold(0, 1'b0, 1'b0);

    // Ack and redirect in the same cycle: data discarded, 0x7C + 4 = 0x80.
    wait_req();
    chk("ackredir_addr0", imem_addr, 32'h44);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    branch = 1'b1; zero = 1'b1; branch_pc = 32'h7C; br_offset = 32'h4;
    step();
    imem_ack = 1'b0; imem_rdata = '0; branch = 1'b0; zero = 1'b0;
    #1;
    chk("ackredir_valid", {31'b0, inst_valid}, 32'd0);
    chk("ackredir_addr1", imem_addr, 32'h80);
    do_fetch(32'h80, 1, mem_word(32'h80));
    do_hold(1, 1'b0, 1'b0);

    // Reset while a fetch is outstanding.
    wait_req();
    chk("midrst_addr", imem_addr, 32'h84);
    step();
    rst = 1'b1;
    #1;
    chk("midrst_req_low", {31'b0, imem_req}, 32'd0);
    step();
    chk("midrst_req_low2", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, inst_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd1);
    chk("midrst_first_addr", imem_addr, 32'h0);
    do_fetch(32'h0, 2, mem_word(32'h0));
    do_hold(0, 1'b0, 1'b0);
    wait_req();
    chk("midrst_next_addr", imem_addr, 32'h4);

    // Second instance: RESET_PC = 0xFFFFFFFC, PC wraps to 0.
    chk("wrap_rst_req", {31'b0, imem_req2}, 32'd0);
    rst2 = 1'b0;
    #1;
    chk("wrap_req", {31'b0, imem_req2}, 32'd1);
    chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    imem_ack2 = 1'b1; imem_rdata2 = 32'h0000_0013;
    step();
    imem_ack2 = 1'b0; imem_rdata2 = '0;
    #1;
    chk("wrap_valid", {31'b0, inst_valid2}, 32'd1);
    chk("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap_inst_out", inst_out2, 32'h0000_0013);
    inst_ready2 = 1'b1;
    step();
    inst_ready2 = 1'b0;
    #1;
    chk("wrap_next_req", {31'b0, imem_req2}, 32'd1);
    chk("wrap_next_addr", imem_addr2, 32'h0);

    // Final report.
    repeat (2) step();
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
